nios2_reset_sequencer: RTL and testbench
========================================

Name: nios2_reset_sequencer

Overview:
Downstream consumer of the Nios II reset-request PIO output bit. Converts a software-driven request level into an ordered reset sequence for the Nios II core:
- request handshake to the core,
- fixed-length reset hold,
- re-arm.
Exposes status and an event counter on a small Avalon-MM slave (zero wait state, read latency 0), in the same clock domain as the PIO.

Parameters:
HOLD_CYCLES, 16, cycles cpu_reset held high per sequence (>=1)
TIMEOUT_CYCLES, 1024, max cycles waiting for ack before forced hold (only with macro)
CNT_W, 16, width of sequence counter (<=16)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
req_in  input  1  reset-request level from PIO out_port, synchronous to clk
cpu_reset_req  output  1  request to Nios II core
cpu_reset_req_ack  input  1  core acknowledge (level)
cpu_reset  output  1  active-high reset to Nios II core
busy  output  1  high whenever state != IDLE
address  input  2  Avalon word address
chipselect  input  1  Avalon select
write_n  input  1  Avalon write, active-low
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, combinational from address and registers

Behaviour:
- Reset (async, any time, including mid-sequence):
  - state=IDLE; req_prev=0.
  - cpu_reset_req=0, cpu_reset=0, busy=0.
  - Counter=0, timeout flag=0.
- All outputs except readdata are registered.
- Edge detect: trigger = req_in & ~req_prev. req_prev is registered every cycle in every state.
- States:
  - IDLE: trigger at edge t -> REQ at t+1, with cpu_reset_req=1 and busy=1 from t+1.
  - REQ: cpu_reset_req=1. Ack sampled high at cycle a -> HOLD at a+1, with cpu_reset_req=0 and cpu_reset=1 from a+1. Ack already high on REQ entry is accepted on the first REQ cycle.
  - HOLD: cpu_reset=1 for exactly HOLD_CYCLES cycles (down-counter loaded on entry) -> REARM.
  - REARM: cpu_reset=0. Counter += 1, saturating at all-ones -> IDLE next cycle.
- Minimum sequence length is HOLD_CYCLES+3 cycles with immediate ack.
- Triggers while busy are ignored. A level still high on return to IDLE does NOT retrigger; a new 0->1 edge is required.
- Register map:
  - addr0 read: [31:16] counter (zero-extended if CNT_W<16), [15:3] 0, [2] timeout flag, [1] cpu_reset, [0] busy.
  - addr1 write (chipselect & ~write_n), writedata[0]=1: clear counter and timeout flag next cycle.
  - Same-cycle clear and increment: clear wins.
  - Reads of addr1..3 return 0. Writes to addr0, 2, 3 are ignored.

Optional Feature:
NIOS2_RESETSEQ_TIMEOUT_EN
- Defined:
  - In REQ, a cycle counter starts at 0 on entry.
  - No ack after TIMEOUT_CYCLES cycles -> HOLD, set timeout flag (sticky until cleared).
  - Ack on the last allowed cycle is treated as normal; flag not set.
- Undefined:
  - REQ waits indefinitely.
  - Timeout flag is constant 0; no timeout counter logic exists.

Test Plan:
- Reset, then idle 10 cycles -> cpu_reset_req=0, cpu_reset=0, busy=0, addr0 readdata=0x00000000.
- req_in 0->1 at cycle 5, ack tied high -> cpu_reset_req=1 at cycle 6 only; cpu_reset=1 cycles 7..22 (HOLD_CYCLES=16); busy low at cycle 24; addr0=0x00010000.
- req_in held high 100 cycles, then toggled 1->0->1 -> exactly one sequence during the hold, second sequence after re-edge; counter=2.
- With macro and TIMEOUT_CYCLES=8, ack tied low -> cpu_reset_req drops after 8 REQ cycles, HOLD follows, addr0 bit2=1. Write addr1 data 0x1 -> addr0 reads 0.
- Reset asserted mid-HOLD -> cpu_reset=0 immediately (async); state IDLE; req_in still high gives no retrigger until a new edge.
- Counter preset near saturation (CNT_W=2, 4 sequences) -> counter reads 3, stays 3; a clear in the same cycle as REARM -> 0.

Source files
------------

// File: rtl/nios2_reset_sequencer.sv
// Reset sequencer for the Nios II core: request/ack handshake, fixed reset hold, re-arm.
// Optional REQ timeout is enabled by defining NIOS2_RESETSEQ_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a 0->1 edge on req_in
// ST_REQ   | cpu_reset_req high, waiting for ack (or timeout)
// ST_HOLD  | cpu_reset high for HOLD_CYCLES cycles
// ST_REARM | cpu_reset low, bump sequence counter, back to idle
module nios2_reset_sequencer #(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_in,
    output logic        cpu_reset_req,
    input  logic        cpu_reset_req_ack,
    output logic        cpu_reset,
    output logic        busy,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_REARM = 2'd3;

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              req_prev;
    logic              edge_en;
    logic              trigger;
    logic              clr;
    logic              tmo_hit;
    logic              tmo_flag;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  seq_cnt;
    logic              unused_wdata;

    // edge_en masks the first cycle after reset so a level already high is stale
    assign trigger      = req_in & ~req_prev & edge_en;
    assign clr          = chipselect & ~write_n & (address == 2'd1) & writedata[0];
    assign unused_wdata = ^writedata[31:1];

`ifdef NIOS2_RESETSEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == ST_REQ) & ~cpu_reset_req_ack & (tmo_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt  <= TMO_LOAD;
            tmo_flag <= 1'b0;
        end else begin
            if (state != ST_REQ)
                tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            if (clr)
                tmo_flag <= 1'b0;
            else if (tmo_hit)
                tmo_flag <= 1'b1;
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign tmo_flag = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (trigger) state_nxt = ST_REQ;
            ST_REQ:   if (cpu_reset_req_ack | tmo_hit) state_nxt = ST_HOLD;
            ST_HOLD:  if (hold_cnt == '0) state_nxt = ST_REARM;
            ST_REARM: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            req_prev      <= 1'b0;
            edge_en       <= 1'b0;
            cpu_reset_req <= 1'b0;
            cpu_reset     <= 1'b0;
            busy          <= 1'b0;
            hold_cnt      <= HOLD_LOAD;
            seq_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            req_prev      <= req_in;
            edge_en       <= 1'b1;
            cpu_reset_req <= (state_nxt == ST_REQ);
            cpu_reset     <= (state_nxt == ST_HOLD);
            busy          <= (state_nxt != ST_IDLE);
            if (state != ST_HOLD)
                hold_cnt <= HOLD_LOAD;
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLD_W'(1);
            // a clear in the REARM cycle wins over the increment
            if (clr)
                seq_cnt <= '0;
            else if ((state == ST_REARM) && (seq_cnt != '1))
                seq_cnt <= seq_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        readdata = '0;
        if (address == 2'd0)
            readdata = {16'(seq_cnt), 13'd0, tmo_flag, cpu_reset, busy};
    end

endmodule

// File: tb/tb_nios2_reset_sequencer.sv
// Self-checking bench for nios2_reset_sequencer: directed scenarios plus random traffic
// checked every cycle against a phase-level model of the reset sequence.
module tb_nios2_reset_sequencer;

    localparam int HOLD    = 16;
    localparam int CNT_W   = 4;
    localparam int TMO     = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_in;
    logic        ack;
    logic        cpu_reset_req;
    logic        cpu_reset;
    logic        busy;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    int n_tests = 0;
    int n_fail  = 0;

    // model: phase flags plus remaining hold cycles
    bit m_prev, m_req, m_rearm, m_flag;
    int m_hold, m_wait, m_cnt;

    always #5 clk = ~clk;

    nios2_reset_sequencer #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_in            (req_in),
        .cpu_reset_req     (cpu_reset_req),
        .cpu_reset_req_ack (ack),
        .cpu_reset         (cpu_reset),
        .busy              (busy),
        .address           (address),
        .chipselect        (chipselect),
        .write_n           (write_n),
        .writedata         (writedata),
        .readdata          (readdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        // a level already high at reset release is not an edge
        m_prev  = 1'b1;
        m_req   = 1'b0;
        m_rearm = 1'b0;
        m_flag  = 1'b0;
        m_hold  = 0;
        m_wait  = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        bit trig, clear, inc, set_flag;
        trig     = req_in && !m_prev;
        clear    = chipselect && !write_n && (address == 2'd1) && writedata[0];
        m_prev   = req_in;
        inc      = 1'b0;
        set_flag = 1'b0;
        if (m_rearm) begin
            m_rearm = 1'b0;
            inc     = 1'b1;
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_rearm = 1'b1;
        end else if (m_req) begin
            m_wait++;
            if (ack) begin
                m_req  = 1'b0;
                m_hold = HOLD;
            end
`ifdef NIOS2_RESETSEQ_TIMEOUT_EN
            else if (m_wait == TMO) begin
                m_req    = 1'b0;
                m_hold   = HOLD;
                set_flag = 1'b1;
            end
`endif
        end else if (trig) begin
            m_req  = 1'b1;
            m_wait = 0;
        end
        if (clear) begin
            m_cnt  = 0;
            m_flag = 1'b0;
        end else begin
            if (inc && m_cnt < CNT_MAX) m_cnt++;
            if (set_flag) m_flag = 1'b1;
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_rd;
        bit          exp_busy;
        exp_busy = m_req || (m_hold > 0) || m_rearm;
        exp_rd   = '0;
        if (address == 2'd0)
            exp_rd = {16'(m_cnt), 13'd0, m_flag, (m_hold > 0), exp_busy};
        check_val("cpu_reset_req", cpu_reset_req, m_req);
        check_val("cpu_reset", cpu_reset, m_hold > 0);
        check_val("busy", busy, exp_busy);
        check_val("readdata", readdata, exp_rd);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_regs();
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd1;
        writedata  = 32'h1;
        tick();
        bus_idle();
    endtask

    task automatic run_sequence();
        req_in = 1'b0;
        tick();
        req_in = 1'b1;
        repeat (HOLD + 6) tick();
    endtask

    initial begin
        int n_req, n_rst, n_busy, first_req, first_rst, waited;
        reset  = 1'b1;
        req_in = 1'b0;
        ack    = 1'b0;
        bus_idle();
        do_reset();

        // idle after reset
        repeat (10) tick();
        check_val("idle_req", cpu_reset_req, 0);
        check_val("idle_rst", cpu_reset, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_rd", readdata, 32'h0);

        // single sequence, ack tied high
        ack       = 1'b1;
        req_in    = 1'b1;
        n_req     = 0;
        n_rst     = 0;
        n_busy    = 0;
        first_req = -1;
        first_rst = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cpu_reset_req) begin n_req++; if (first_req < 0) first_req = i; end
            if (cpu_reset) begin n_rst++; if (first_rst < 0) first_rst = i; end
            if (busy) n_busy++;
        end
        check_val("seq_req_cycles", n_req, 1);
        check_val("seq_first_req", first_req, 0);
        check_val("seq_rst_cycles", n_rst, HOLD);
        check_val("seq_first_rst", first_rst, 1);
        check_val("seq_busy_cycles", n_busy, HOLD + 2);
        check_val("seq_rd", readdata, 32'h0001_0000);

        // level held high must not retrigger
        repeat (100) tick();
        check_val("hold_level_rd", readdata, 32'h0001_0000);
        run_sequence();
        check_val("reedge_rd", readdata, 32'h0002_0000);

        // ack held low
        ack    = 1'b0;
        req_in = 1'b0;
        tick();
        req_in = 1'b1;
`ifdef NIOS2_RESETSEQ_TIMEOUT_EN
        n_req = 0;
        for (int i = 0; i < HOLD + 20; i++) begin
            tick();
            if (cpu_reset_req) n_req++;
        end
        check_val("tmo_req_cycles", n_req, TMO);
        check_val("tmo_rd", readdata, 32'h0003_0004);
`else
        repeat (50) tick();
        check_val("noack_req", cpu_reset_req, 1);
        check_val("noack_rst", cpu_reset, 0);
        ack = 1'b1;
        repeat (HOLD + 6) tick();
        check_val("noack_rd", readdata, 32'h0003_0000);
`endif
        ack = 1'b1;
        clear_regs();
        tick();
        check_val("clear_rd", readdata, 32'h0);

        // async reset in the middle of HOLD
        run_sequence();
        req_in = 1'b0;
        tick();
        req_in = 1'b1;
        repeat (6) tick();
        check_val("pre_reset_rst", cpu_reset, 1);
        #2 reset = 1'b1;
        #1;
        check_val("async_rst", cpu_reset, 0);
        check_val("async_busy", busy, 0);
        check_val("async_req", cpu_reset_req, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (20) tick();
        check_val("no_retrigger", busy, 0);
        req_in = 1'b0;
        tick();
        req_in = 1'b1;
        tick();
        check_val("new_edge_req", cpu_reset_req, 1);
        repeat (HOLD + 6) tick();

        // saturation
        clear_regs();
        for (int s = 0; s < CNT_MAX + 2; s++) run_sequence();
        check_val("sat_cnt", readdata[31:16], CNT_MAX);
        run_sequence();
        check_val("sat_stay", readdata[31:16], CNT_MAX);

        // clear coinciding with the REARM increment
        req_in = 1'b0;
        tick();
        req_in = 1'b1;
        waited = 0;
        while (!m_rearm && waited < 60) begin
            tick();
            waited++;
        end
        check_val("rearm_reached", m_rearm, 1);
        clear_regs();
        tick();
        check_val("clear_vs_inc", readdata[31:16], 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) req_in = ~req_in;
            ack        = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom_range(0, 3));
            chipselect = $urandom_range(0, 1) == 1;
            write_n    = ($urandom_range(0, 39) != 0);
            writedata  = $urandom;
            tick();
        end
        bus_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
